// File: rtl/fifo_port_arbiter_if.sv
// Requester-side handshake bundle for the FIFO port arbiter.
interface fifo_port_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_req;
  logic             rd_ack;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  // Arbiter side
  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_req,
    output wr_ready,
    output rd_ack,
    output rd_valid,
    output rd_data
  );

  // Requester side
  modport master (
    output wr_valid,
    output wr_data,
    output rd_req,
    input  wr_ready,
    input  rd_ack,
    input  rd_valid,
    input  rd_data
  );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Round-robin arbiter sharing one FIFO port between a writer and a reader.
// A write occupies the port for one cycle after acceptance; a read issues
// oe_n for one cycle and captures fifo_dout one cycle later.
module fifo_port_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_port_arbiter_if.slave req,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_we_n,
  output logic             fifo_oe_n,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_READ    = 2'd2,
    S_RD_WAIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_we_n;
  logic             r_oe_n;
  logic             r_busy;
  logic             r_last_rd;

  logic w_idle;
  logic w_wr_elig;
  logic w_rd_elig;
  logic w_wr_grant;
  logic w_rd_grant;

  // Eligibility and round-robin grant decision, only meaningful in IDLE
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_wr_elig  = req.wr_valid & ~fifo_full;
    w_rd_elig  = req.rd_req & ~fifo_empty;
    w_wr_grant = w_idle & w_wr_elig & (~w_rd_elig | r_last_rd);
    w_rd_grant = w_idle & w_rd_elig & (~w_wr_elig | ~r_last_rd);
  end

  // FSM with registered FIFO strobes, status and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_last_rd  <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wr_grant) begin
            r_state   <= S_WRITE;
            r_hold    <= req.wr_data;
            r_we_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_last_rd <= 1'b0;
          end else if (w_rd_grant) begin
            r_state   <= S_READ;
            r_oe_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_last_rd <= 1'b1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_we_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_READ: begin
          r_state <= S_RD_WAIT;
          r_oe_n  <= 1'b1;
        end
        S_RD_WAIT: begin
          r_state    <= S_IDLE;
          r_rd_data  <= fifo_dout;
          r_rd_valid <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_we_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Hold register doubles as the FIFO data bus so it stays quiet between writes
  assign fifo_din     = r_hold;
  assign fifo_we_n    = r_we_n;
  assign fifo_oe_n    = r_oe_n;
  assign busy         = r_busy;
  assign req.wr_ready = w_wr_grant;
  assign req.rd_ack   = w_rd_grant;
  assign req.rd_valid = r_rd_valid;
  assign req.rd_data  = r_rd_data;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Bench for fifo_port_arbiter: a FIFO model plus a transaction-level
// reference that schedules each grant's observable effects in time.
module tb_fifo_port_arbiter;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_we_n;
  logic             fifo_oe_n;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             busy;

  fifo_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

  fifo_port_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .fifo_din   (fifo_din),
    .fifo_we_n  (fifo_we_n),
    .fifo_oe_n  (fifo_oe_n),
    .fifo_dout  (fifo_dout),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model; pre_push lets the bench seed contents while the arbiter is in reset
  logic [WIDTH-1:0] mem[$];
  int               fcnt = 0;
  logic             pre_push = 1'b0;
  logic [WIDTH-1:0] pre_data = '0;
  logic             force_full = 1'b0;
  logic             force_empty = 1'b0;

  always @(posedge clk) begin
    if (pre_push) mem.push_back(pre_data);
    if (!fifo_we_n) mem.push_back(fifo_din);
    if (!fifo_oe_n && mem.size() > 0) fifo_dout <= mem.pop_front();
    fcnt = mem.size();
  end

  assign fifo_full  = (fcnt >= DEPTH) | force_full;
  assign fifo_empty = (fcnt == 0) | force_empty;

  // Port enables must never overlap
  always @(negedge clk)
    if (rst_n) assert (fifo_we_n | fifo_oe_n) else $error("FAIL excl_assert: we_n=%0b oe_n=%0b", fifo_we_n, fifo_oe_n);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each grant schedules when the port strobes, the busy window and rd_valid occur
  int               cyc, idle_at, we_due, oe_due, rv_due;
  bit               last_w;
  logic [WIDTH-1:0] exp_din, exp_rd, rv_dat;
  logic [WIDTH-1:0] exp_q[$];
  logic             obs_wr_ready, obs_rd_ack;

  task automatic model_reset();
    cyc = 0; idle_at = 0; we_due = -10; oe_due = -10; rv_due = -10;
    last_w = 1'b0; exp_din = '0; exp_rd = '0; rv_dat = '0;
    exp_q = mem;
  endtask

  // One clock: check at the falling edge, then advance the reference after the rising edge
  task automatic step(output bit gw, output bit gr);
    bit idle, we, re;
    @(negedge clk);
    idle = (cyc >= idle_at);
    we   = bus.wr_valid & ~fifo_full;
    re   = bus.rd_req & ~fifo_empty;
    gw   = idle & we & (!re | !last_w);
    gr   = idle & re & !gw;
    if (cyc == rv_due) exp_rd = rv_dat;
    obs_wr_ready = bus.wr_ready;
    obs_rd_ack   = bus.rd_ack;
    check_val("wr_ready", 32'(bus.wr_ready), 32'(gw));
    check_val("rd_ack", 32'(bus.rd_ack), 32'(gr));
    check_val("busy", 32'(busy), 32'(!idle));
    check_val("fifo_we_n", 32'(fifo_we_n), 32'(cyc != we_due));
    check_val("fifo_oe_n", 32'(fifo_oe_n), 32'(cyc != oe_due));
    check_val("fifo_din", 32'(fifo_din), 32'(exp_din));
    check_val("rd_valid", 32'(bus.rd_valid), 32'(cyc == rv_due));
    check_val("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    @(posedge clk); #1;
    if (gw) begin
      we_due = cyc + 1; idle_at = cyc + 2; exp_din = bus.wr_data; last_w = 1'b1;
      exp_q.push_back(bus.wr_data);
    end
    if (gr) begin
      oe_due = cyc + 1; idle_at = cyc + 3; rv_due = cyc + 3; last_w = 1'b0;
      rv_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    end
    cyc++;
  endtask

  task automatic apply_reset(input int npre);
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0; force_full = 1'b0; force_empty = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rst_we_n", 32'(fifo_we_n), 32'd1);
    check_val("rst_oe_n", 32'(fifo_oe_n), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_val("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check_val("rst_fifo_din", 32'(fifo_din), 32'd0);
    for (int i = 0; i < npre; i++) begin
      pre_data = WIDTH'($urandom);
      pre_push = 1'b1;
      @(posedge clk); #1;
      pre_push = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  bit gw, gr;
  int k;

  initial begin
    rst_n = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
    #2;
    apply_reset(0);

    // Single write of 0xA5 into an empty FIFO
    bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
    step(gw, gr);
    check_val("w1_ready", 32'(obs_wr_ready), 32'd1);
    bus.wr_valid = 1'b0;
    step(gw, gr);
    step(gw, gr);
    check_val("w1_din_held", 32'(fifo_din), 32'hA5);

    // Read it back: rd_valid three cycles after rd_ack
    bus.rd_req = 1'b1;
    step(gw, gr);
    check_val("r1_ack", 32'(obs_rd_ack), 32'd1);
    bus.rd_req = 1'b0;
    repeat (3) step(gw, gr);
    check_val("r1_data", 32'(bus.rd_data), 32'hA5);

    // Tie: both eligible after a fresh reset, grants alternate starting with write
    apply_reset(1);
    bus.wr_valid = 1'b1; bus.wr_data = WIDTH'($urandom); bus.rd_req = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      step(gw, gr);
      if (gw || gr) begin
        check_val("tie_order", 32'(gw), 32'(k % 2 == 0));
        k++;
      end
      if (gw) bus.wr_data = WIDTH'($urandom);
    end
    check_val("tie_count", 32'(k), 32'd6);
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
    repeat (3) step(gw, gr);

    // Full: writes withheld while a read still proceeds
    force_full = 1'b1; bus.wr_valid = 1'b1; bus.rd_req = 1'b1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(gw, gr);
      check_val("full_wr_ready", 32'(obs_wr_ready), 32'd0);
      if (obs_rd_ack) k++;
    end
    check_val("full_rd_went", 32'(k > 0), 32'd1);
    force_full = 1'b0; bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
    repeat (3) step(gw, gr);

    // Empty: reads withheld
    force_empty = 1'b1; bus.rd_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(gw, gr);
      check_val("empty_rd_ack", 32'(obs_rd_ack), 32'd0);
    end
    force_empty = 1'b0; bus.rd_req = 1'b0;

    // Reset during READ aborts the access with no rd_valid pulse
    bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
    gw = 1'b0;
    for (int c = 0; c < 8 && !gw; c++) step(gw, gr);
    bus.wr_valid = 1'b0;
    step(gw, gr);
    bus.rd_req = 1'b1;
    gr = 1'b0;
    for (int c = 0; c < 8 && !gr; c++) step(gw, gr);
    check_val("abort_granted", 32'(gr), 32'd1);
    bus.rd_req = 1'b0;
    check_val("abort_oe_pre", 32'(fifo_oe_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_oe_n", 32'(fifo_oe_n), 32'd1);
    check_val("abort_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    repeat (4) step(gw, gr);
    bus.rd_req = 1'b1;
    step(gw, gr);
    bus.rd_req = 1'b0;
    repeat (3) step(gw, gr);
    check_val("abort_reread", 32'(bus.rd_data), 32'h3C);

    // Random traffic with occasional forced status flags
    for (int c = 0; c < 10000; c++) begin
      force_full  = ($urandom_range(0, 7) == 0);
      force_empty = ($urandom_range(0, 7) == 0);
      if (!bus.wr_valid && $urandom_range(0, 1) == 1) begin
        bus.wr_valid = 1'b1; bus.wr_data = WIDTH'($urandom);
      end
      if (!bus.rd_req && $urandom_range(0, 1) == 1) bus.rd_req = 1'b1;
      step(gw, gr);
      if (gw) bus.wr_valid = 1'b0;
      if (gr) bus.rd_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_port_arbiter.md
FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port wr_valid, input, 1 bit: the writer requester has data to push.
REQ-005 The module SHALL have port wr_data, input, WIDTH bits: the write payload, sampled when wr_ready=1.
REQ-006 The module SHALL have port wr_ready, output, 1 bit: the write request is accepted this cycle.
REQ-007 The module SHALL have port rd_req, input, 1 bit: the reader requester wants one word popped.
REQ-008 The module SHALL have port rd_ack, output, 1 bit: the read request is accepted this cycle.
REQ-009 The module SHALL have port rd_valid, output, 1 bit: a one-cycle pulse marking rd_data as valid.
REQ-010 The module SHALL have port rd_data, output, WIDTH bits: the popped word, held until the next pop.
REQ-011 The module SHALL have port fifo_din, output, WIDTH bits: the data bus to the FIFO.
REQ-012 The module SHALL have port fifo_we_n, output, 1 bit: the active-low FIFO write enable.
REQ-013 The module SHALL have port fifo_oe_n, output, 1 bit: the active-low FIFO read enable.
REQ-014 The module SHALL have port fifo_dout, input, WIDTH bits: FIFO read data, valid the cycle after the oe_n=0 edge.
REQ-015 The module SHALL have ports fifo_full and fifo_empty, input, 1 bit each: the FIFO status flags.
REQ-016 The module SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, WRITE, READ and RD_WAIT, one-hot or binary.
REQ-018 In IDLE: wr_elig = wr_valid & ~fifo_full; rd_elig = rd_req & ~fifo_empty.
REQ-019 In IDLE, if exactly one requester is eligible, that requester SHALL be granted.
REQ-020 In IDLE, if both requesters are eligible, the requester not granted most recently SHALL win (round-robin); last_grant resets to "read", so a write wins the first tie.
REQ-021 On a write grant: wr_ready=1 (combinational, IDLE only); wr_data latched into a hold register; last_grant<=write; next state WRITE.
REQ-022 On a read grant: rd_ack=1 (combinational, IDLE only); last_grant<=read; next state READ.
REQ-023 WRITE lasts exactly 1 cycle: fifo_we_n=0, fifo_oe_n=1, fifo_din=hold register; then next state IDLE.
REQ-024 READ lasts exactly 1 cycle: fifo_oe_n=0, fifo_we_n=1; then next state RD_WAIT.
REQ-025 RD_WAIT lasts exactly 1 cycle: fifo_dout is registered into rd_data at its closing edge, rd_valid<=1 for the following cycle, and the next state is IDLE.
REQ-026 fifo_we_n and fifo_oe_n SHALL never be 0 simultaneously; both SHALL be 1 in IDLE and RD_WAIT.
REQ-027 Latency: write acceptance to fifo_we_n=0 is 1 cycle; rd_ack to rd_valid is 3 cycles.
REQ-028 Throughput: at most one write per 2 cycles and one read per 3 cycles.
REQ-029 With neither requester eligible, the FSM SHALL remain in IDLE with wr_ready=rd_ack=0.
REQ-030 When fifo_full=1, writes SHALL be withheld (wr_ready=0) while eligible reads proceed.
REQ-031 When fifo_empty=1, reads SHALL be withheld (rd_ack=0) while eligible writes proceed.
REQ-032 Requests arriving in a non-IDLE state SHALL be ignored until IDLE; requesters hold their request until accepted.
REQ-033 busy SHALL be 1 in WRITE, READ and RD_WAIT, and 0 in IDLE.
REQ-034 fifo_din SHALL hold the last written data outside WRITE, so it does not toggle.

Reset
REQ-035 When rst_n=0, outputs SHALL immediately and asynchronously take these values: state=IDLE, fifo_we_n=1, fifo_oe_n=1, rd_valid=0, rd_data=0, fifo_din=0, hold register=0, last_grant=read, busy=0.
REQ-036 A reset during WRITE or READ SHALL abort the access with no rd_valid pulse; after release the FSM SHALL start in IDLE.
REQ-037 The first rising edge with rst_n=1 SHALL perform a normal IDLE evaluation.

Verification
REQ-038 Reset: assert rst_n=0 mid-READ -> fifo_oe_n=1 and busy=0 before the next edge; no rd_valid pulse.
REQ-039 Single write: wr_valid=1, wr_data=8'hA5, empty FIFO -> wr_ready=1 in cycle 0; fifo_we_n=0 with fifo_din=8'hA5 in cycle 1; IDLE in cycle 2.
REQ-040 Write then read: after REQ-039, rd_req=1 -> rd_ack at t, fifo_oe_n=0 at t+1, rd_valid=1 with rd_data=8'hA5 at t+3.
REQ-041 Tie: both requesters eligible continuously, FIFO neither full nor empty -> grants alternate W,R,W,R, starting with W after reset.
REQ-042 Boundaries: fifo_full=1 with wr_valid=1 -> wr_ready stays 0 while reads still proceed; fifo_empty=1 with rd_req=1 -> rd_ack stays 0.
REQ-043 Protocol check: an assertion that fifo_we_n and fifo_oe_n are never both 0 holds over 10k random cycles.
